// File: rtl/spongent_pkg.sv
// Shared SPONGENT constants: S-box table, per-variant defaults, LFSR and bit-reverse helpers.
// Helpers work on a fixed-width container so one definition serves every LFSR width.
package spongent_pkg;

    localparam int              SPG88_B          = 88;
    localparam int              SPG88_ROUNDS     = 45;
    localparam int              SPG88_LFSR_W     = 6;
    localparam logic [5:0]      SPG88_LFSR_INIT  = 6'h05;

    localparam int              SPG136_B         = 136;
    localparam int              SPG136_ROUNDS    = 70;
    localparam int              SPG136_LFSR_W    = 7;
    localparam logic [6:0]      SPG136_LFSR_INIT = 7'h7A;

    localparam int              LFSR_MAX_W       = 16;

    localparam logic [3:0] SBOX [16] = '{
        4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
        4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6
    };

    // Shift left, feedback = top two bits XORed; result masked to w bits.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] v,
                                                        input int w);
        logic [LFSR_MAX_W-1:0] r;
        r = {v[LFSR_MAX_W-2:0], v[w-1] ^ v[w-2]};
        r = r & ((LFSR_MAX_W'(1) << w) - LFSR_MAX_W'(1));
        return r;
    endfunction

    function automatic logic [LFSR_MAX_W-1:0] bit_reverse(input logic [LFSR_MAX_W-1:0] v,
                                                          input int w);
        logic [LFSR_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < LFSR_MAX_W; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spongent_player.sv
// SPONGENT bit permutation: bit i moves to (i*B/4) mod (B-1); the MSB stays in place.
module spongent_player #(
    parameter int SPONGENT_B = 136
) (
    input  logic [SPONGENT_B-1:0] state_i,
    output logic [SPONGENT_B-1:0] state_o
);

    for (genvar i = 0; i < SPONGENT_B - 1; i++) begin : g_perm
        assign state_o[(i * (SPONGENT_B / 4)) % (SPONGENT_B - 1)] = state_i[i];
    end

    assign state_o[SPONGENT_B-1] = state_i[SPONGENT_B-1];

endmodule

// File: rtl/spongent_slayer.sv
// SPONGENT S-box layer: SPONGENT_B/4 parallel 4-bit S-boxes, purely combinational.
module spongent_slayer
    import spongent_pkg::*;
#(
    parameter int SPONGENT_B = 136
) (
    input  logic [SPONGENT_B-1:0] state_i,
    output logic [SPONGENT_B-1:0] state_o
);

    for (genvar k = 0; k < SPONGENT_B / 4; k++) begin : g_sbox
        assign state_o[4*k +: 4] = SBOX[state_i[4*k +: 4]];
    end

endmodule

// File: rtl/spongent_round_engine.sv
// Iterative SPONGENT permutation: one round (constant add, S-layer, P-layer) per clock.
// Done pulses ROUNDS edges after the load edge; start is ignored while busy.
module spongent_round_engine
    import spongent_pkg::*;
#(
    parameter int                    SPONGENT_B = SPG136_B,
    parameter int                    ROUNDS     = SPG136_ROUNDS,
    parameter int                    LFSR_WIDTH = SPG136_LFSR_W,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = SPG136_LFSR_INIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SPONGENT_B-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [SPONGENT_B-1:0] data_out
);

    localparam int              CNT_W    = $clog2(ROUNDS + 1);
    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);
    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_RUN   = 1'b1;

    logic [0:0]            fsm_q,   fsm_d;
    logic [SPONGENT_B-1:0] state_q, state_d;
    logic [LFSR_WIDTH-1:0] lfsr_q,  lfsr_d;
    logic [CNT_W-1:0]      rnd_q,   rnd_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;

    logic [LFSR_WIDTH-1:0] lfsr_rev;
    logic [LFSR_WIDTH-1:0] lfsr_step;
    logic [SPONGENT_B-1:0] rc_state;
    logic [SPONGENT_B-1:0] sl_out;
    logic [SPONGENT_B-1:0] pl_out;

    always_comb begin
        lfsr_rev  = LFSR_WIDTH'(bit_reverse(LFSR_MAX_W'(lfsr_q), LFSR_WIDTH));
        lfsr_step = LFSR_WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_q), LFSR_WIDTH));
    end

    // Round constant touches both ends of the state: LFSR at the bottom, its mirror at the top.
    always_comb begin
        rc_state = state_q;
        rc_state[LFSR_WIDTH-1:0] = state_q[LFSR_WIDTH-1:0] ^ lfsr_q;
        rc_state[SPONGENT_B-1 -: LFSR_WIDTH] = state_q[SPONGENT_B-1 -: LFSR_WIDTH] ^ lfsr_rev;
    end

    spongent_slayer #(
        .SPONGENT_B (SPONGENT_B)
    ) u_slayer (
        .state_i (rc_state),
        .state_o (sl_out)
    );

    spongent_player #(
        .SPONGENT_B (SPONGENT_B)
    ) u_player (
        .state_i (sl_out),
        .state_o (pl_out)
    );

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        lfsr_d  = lfsr_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = data_in;
                    lfsr_d  = LFSR_INIT;
                    rnd_d   = '0;
                    busy_d  = 1'b1;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = pl_out;
                lfsr_d  = lfsr_step;
                rnd_d   = rnd_q + CNT_W'(1);
                if (rnd_q == LAST_RND) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    fsm_d  = ST_IDLE;
                end
            end
            default: begin
                busy_d = 1'b0;
                fsm_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            lfsr_q  <= LFSR_INIT;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = state_q;

endmodule

// File: tb/tb_spongent_round_engine.sv
// Directed bench for spongent_round_engine: default 136-bit core plus a one-round 88-bit core.
module tb_spongent_round_engine;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [135:0] data_in = '0;
    logic         busy, done;
    logic [135:0] data_out;

    logic         s_start = 1'b0;
    logic [87:0]  s_data_in = '0;
    logic         s_busy, s_done;
    logic [87:0]  s_data_out;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spongent_round_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    spongent_round_engine #(
        .SPONGENT_B (88),
        .ROUNDS     (1),
        .LFSR_WIDTH (6),
        .LFSR_INIT  (6'h05)
    ) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (s_start),
        .data_in  (s_data_in),
        .busy     (s_busy),
        .done     (s_done),
        .data_out (s_data_out)
    );

    task automatic chk(input string tag, input logic [135:0] act, input logic [135:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [3:0] s_model(input logic [3:0] x);
        logic [63:0] t;
        t = 64'hEDB0214F7A859C36;
        return t[(15 - int'(x)) * 4 +: 4];
    endfunction

    function automatic logic [135:0] p_model(input logic [135:0] s, input int b);
        logic [135:0] r;
        r = '0;
        for (int i = 0; i < b - 1; i++) r[(i * (b / 4)) % (b - 1)] = s[i];
        r[b-1] = s[b-1];
        return r;
    endfunction

    function automatic logic [135:0] golden(input logic [135:0] d);
        logic [135:0] s;
        logic [6:0]   l;
        s = d;
        l = 7'h7A;
        for (int r = 0; r < 70; r++) begin
            s[6:0] = s[6:0] ^ l;
            for (int i = 0; i < 7; i++) s[129+i] = s[129+i] ^ l[6-i];
            for (int k = 0; k < 34; k++) s[4*k +: 4] = s_model(s[4*k +: 4]);
            s = p_model(s, 136);
            l = {l[5:0], l[6] ^ l[5]};
        end
        return s;
    endfunction

    task automatic launch(input logic [135:0] d);
        @(negedge clk);
        data_in = d;
        start   = 1'b1;
    endtask

    // Edge 1 is the load edge; returns in the negedge where done is first seen.
    task automatic wait_done(input int inj_edge, input logic [135:0] inj_data,
                             output int busy_cnt, output int done_edge, output logic first_busy,
                             output logic [135:0] res, output logic [6:0] l1,
                             output logic [6:0] l2, output logic [6:0] l3);
        busy_cnt = 0; done_edge = -1; first_busy = 1'b0; res = '0;
        l1 = '0; l2 = '0; l3 = '0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start      = 1'b0;
                data_in    = ~data_in;
                first_busy = busy;
                l1         = dut.lfsr_q;
            end
            if (j == 2) l2 = dut.lfsr_q;
            if (j == 3) l3 = dut.lfsr_q;
            if (inj_edge != 0 && j == inj_edge) begin
                start   = 1'b1;
                data_in = inj_data;
            end
            if (inj_edge != 0 && j == inj_edge + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_edge = j;
                res       = data_out;
                break;
            end
        end
    endtask

    task automatic after_done(input int n, output int extra_done, output int extra_busy);
        extra_done = 0; extra_busy = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
    endtask

    initial begin
        int           bc, de, xd, xb;
        logic         fb;
        logic [135:0] res;
        logic [6:0]   l1, l2, l3;
        logic [135:0] pat_a, pat_b, pat_c;
        logic [87:0]  pre_p;

        pat_a = 136'h0123456789abcdeffedcba9876543210a5;
        pat_b = {17{8'h3C}};
        pat_c = {34{4'h9}};
        pre_p = 88'h8EEEEEEEEEEEEEEEEEEEE1;

        // Reset then idle
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", {busy, done, data_out}, '0);
        end
        chk("reset_lfsr", 136'(dut.lfsr_q), 136'h7A);
        chk("reset_rnd", 136'(dut.rnd_q), '0);
        chk("small_idle", {s_busy, s_done, s_data_out}, '0);

        // Default run of zero, LFSR sequence, data_in changed after load
        launch('0);
        wait_done(0, '0, bc, de, fb, res, l1, l2, l3);
        chk("run0_first_busy", 136'(fb), 136'(1));
        chk("run0_lfsr_r0", 136'(l1), 136'h7A);
        chk("run0_lfsr_r1", 136'(l2), 136'h74);
        chk("run0_lfsr_r2", 136'(l3), 136'h68);
        chk("run0_busy_cycles", 136'(bc), 136'(70));
        chk("run0_done_edge", 136'(de), 136'(71));
        chk("run0_busy_at_done", 136'(busy), '0);
        chk("run0_result", res, golden('0));
        after_done(20, xd, xb);
        chk("run0_single_done", 136'(xd), '0);
        chk("run0_hold", data_out, golden('0));

        // Single-round 88-bit hand check
        @(negedge clk);
        s_data_in = '0;
        s_start   = 1'b1;
        @(negedge clk);
        s_start   = 1'b0;
        chk("small_busy", 136'(s_busy), 136'(1));
        chk("small_pre_player", 136'(dut_s.sl_out), 136'(pre_p));
        @(negedge clk);
        chk("small_done", {s_busy, s_done}, 136'b01);
        chk("small_result", 136'(s_data_out), p_model(136'(pre_p), 88));

        // Start while busy is ignored
        launch(pat_a);
        wait_done(10, pat_b, bc, de, fb, res, l1, l2, l3);
        chk("ign_busy_cycles", 136'(bc), 136'(70));
        chk("ign_done_edge", 136'(de), 136'(71));
        chk("ign_result", res, golden(pat_a));
        after_done(90, xd, xb);
        chk("ign_no_second_run", {32'(xd), 32'(xb)}, '0);

        // Back-to-back: restart in the done cycle
        launch(pat_c);
        wait_done(0, '0, bc, de, fb, res, l1, l2, l3);
        chk("b2b_first_result", res, golden(pat_c));
        data_in = pat_b;
        start   = 1'b1;
        wait_done(0, '0, bc, de, fb, res, l1, l2, l3);
        chk("b2b_busy_next", 136'(fb), 136'(1));
        chk("b2b_done_edge", 136'(de), 136'(71));
        chk("b2b_second_result", res, golden(pat_b));

        // Mid-run reset at round 35
        launch(pat_a);
        for (int j = 1; j <= 35; j++) begin
            @(negedge clk);
            if (j == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_outputs", {busy, done, data_out}, '0);
        after_done(100, xd, xb);
        chk("abort_no_done", {32'(xd), 32'(xb)}, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
